// File: rtl/xb_mm_pkg.sv
// xb_mm_pkg: shared constants, FSM states and helpers for the multi-channel register bridge
package xb_mm_pkg;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_E220;
    localparam int WR_BIT = 31;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/xb_sync_fifo.sv
// xb_sync_fifo: synchronous FIFO with FWFT head/next, registered read port, count and sync flush
module xb_sync_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    input  logic                         rd_two,
    output logic [W-1:0]                 head,
    output logic [W-1:0]                 head_nx,
    output logic [W-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    logic [1:0] step;
    function automatic logic [AW-1:0] adv(input logic [AW-1:0] p, input int n);
        return AW'((int'(p) + n) % DEPTH);
    endfunction
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign step = rd_two ? 2'd2 : 2'd1;
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && 32'(count) >= 32'(step);
    assign head = mem[rp];
    assign head_nx = mem[adv(rp, 1)];
    always_ff @(posedge clk)
        if (wr_ok && !flush) mem[wp] <= wr_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= adv(wp, 1);
            if (rd_ok) begin
                rp <= adv(rp, int'(step));
                rd_data <= head;
            end
            count <= count + CW'(wr_ok) - (rd_ok ? CW'(step) : '0);
        end
endmodule

// File: rtl/xb_mm_bridge.sv
// xb_mm_bridge: round-robin bridge from NCH host request streams onto one register bus with per-channel responses
module xb_mm_bridge
    import xb_mm_pkg::*;
#(
    parameter int NCH = 4,
    parameter int ADDR_W = 24,
    parameter int REQ_DEPTH = 16,
    parameter int RSP_DEPTH = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     bus_clk,
    input  logic                     trn_reset_n,
    input  logic [NCH*32-1:0]        user_w_mmreq_data,
    input  logic [NCH-1:0]           user_w_mmreq_wren,
    input  logic [NCH-1:0]           user_w_mmreq_open,
    output logic [NCH-1:0]           user_w_mmreq_full,
    output logic [NCH*32-1:0]        user_r_mmresp_data,
    input  logic [NCH-1:0]           user_r_mmresp_rden,
    input  logic [NCH-1:0]           user_r_mmresp_open,
    output logic [NCH-1:0]           user_r_mmresp_empty,
    output logic [NCH-1:0]           user_r_mmresp_eof,
    output logic                     reg_req_o,
    output logic                     reg_we_o,
    output logic [ADDR_W-1:0]        reg_addr_o,
    output logic [31:0]              reg_wdata_o,
    output logic [ch_w(NCH)-1:0]     reg_ch_o,
    input  logic                     reg_ack_i,
    input  logic [31:0]              reg_rdata_i,
    output logic                     timeout_o
);
    localparam int CHW = ch_w(NCH);
    localparam int QW = $clog2(REQ_DEPTH + 1);
    localparam int SW = $clog2(RSP_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [31:0] hd [NCH];
    logic [31:0] nx [NCH];
    logic [31:0] unused_req_rd [NCH];
    logic [31:0] unused_rsp_hd [NCH];
    logic [31:0] unused_rsp_nx [NCH];
    logic [QW-1:0] qcnt [NCH];
    logic [SW-1:0] scnt [NCH];
    logic [NCH-1:0] elig, pop, push, unused_bits, unused_req_empty, unused_rsp_full;
    logic [CHW-1:0] rr, gnt, idx;
    logic [TW-1:0] timer;
    logic [31:0] push_data;
    logic found, expire, done;
    state_t state;
    assign user_r_mmresp_eof = '0;
    assign expire = timer == TW'(TIMEOUT - 1);
    assign done = state == WAIT && (reg_ack_i || expire);
    assign push_data = reg_ack_i ? reg_rdata_i : ERR_WORD;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        xb_sync_fifo #(.W(32), .DEPTH(REQ_DEPTH)) u_req (
            .clk(bus_clk), .rst_n(trn_reset_n), .flush(!user_w_mmreq_open[c]),
            .wr_en(user_w_mmreq_wren[c]), .wr_data(user_w_mmreq_data[32*c +: 32]),
            .rd_en(pop[c]), .rd_two(hd[c][WR_BIT]),
            .head(hd[c]), .head_nx(nx[c]), .rd_data(unused_req_rd[c]),
            .count(qcnt[c]), .full(user_w_mmreq_full[c]), .empty(unused_req_empty[c])
        );
        xb_sync_fifo #(.W(32), .DEPTH(RSP_DEPTH)) u_rsp (
            .clk(bus_clk), .rst_n(trn_reset_n), .flush(!user_r_mmresp_open[c]),
            .wr_en(push[c]), .wr_data(push_data),
            .rd_en(user_r_mmresp_rden[c]), .rd_two(1'b0),
            .head(unused_rsp_hd[c]), .head_nx(unused_rsp_nx[c]), .rd_data(user_r_mmresp_data[32*c +: 32]),
            .count(scnt[c]), .full(unused_rsp_full[c]), .empty(user_r_mmresp_empty[c])
        );
        // a read only goes out when its response is guaranteed a slot
        assign elig[c] = user_w_mmreq_open[c] && (hd[c][WR_BIT] ? 32'(qcnt[c]) >= 32'd2
                         : (qcnt[c] != '0 && 32'(scnt[c]) < RSP_DEPTH));
        assign pop[c] = state == IDLE && found && gnt == CHW'(c);
        assign push[c] = done && !reg_we_o && reg_ch_o == CHW'(c);
        assign unused_bits[c] = ^hd[c][30:ADDR_W];
    end
    // descending scan so the first eligible channel at or after rr wins
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CHW'((int'(rr) + i) % NCH);
            if (elig[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end
    always_ff @(posedge bus_clk or negedge trn_reset_n)
        if (!trn_reset_n) begin
            state <= IDLE;
            reg_req_o <= 1'b0;
            reg_we_o <= 1'b0;
            reg_addr_o <= '0;
            reg_wdata_o <= '0;
            reg_ch_o <= '0;
            timeout_o <= 1'b0;
            timer <= '0;
            rr <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    state <= ISSUE;
                    reg_we_o <= hd[gnt][WR_BIT];
                    reg_addr_o <= hd[gnt][ADDR_W-1:0];
                    reg_wdata_o <= hd[gnt][WR_BIT] ? nx[gnt] : '0;
                    reg_ch_o <= gnt;
                    rr <= CHW'((int'(gnt) + 1) % NCH);
                end
                ISSUE: begin
                    state <= WAIT;
                    reg_req_o <= 1'b1;
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (done) begin
                        state <= IDLE;
                        reg_req_o <= 1'b0;
                        timeout_o <= !reg_ack_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_xb_mm_bridge.sv
// tb_xb_mm_bridge: directed and randomized checks of the bridge against a queue-based reference model
module tb_xb_mm_bridge;
    localparam int NCH = 4;
    localparam logic [31:0] ERR = 32'hDEAD_E220;
    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [1:0]  ch;
    } tr_t;
    logic bus_clk = 1'b0;
    logic trn_reset_n;
    logic [NCH*32-1:0] wdata_bus, rsp_data;
    logic [NCH-1:0] wren, wopen, req_full, rden, ropen, rsp_empty, rsp_eof;
    logic reg_req_o, reg_we_o, reg_ack_i, timeout_o;
    logic [23:0] reg_addr_o;
    logic [31:0] reg_wdata_o, reg_rdata_i, rd_val;
    logic [1:0] reg_ch_o;
    int total = 0, bad = 0;
    int ack_delay = 1, wcnt = 0, last_hi = 0, to_cnt = 0, late_req = 0, late_done = 0;
    logic use_fn = 1'b1;
    tr_t log_q[$];
    tr_t exp_tr [NCH][$];
    logic [31:0] exp_rsp [NCH][$];
    logic [31:0] got_q [NCH][$];

    xb_mm_bridge #(.NCH(NCH), .ADDR_W(24), .REQ_DEPTH(16), .RSP_DEPTH(2), .TIMEOUT(8)) dut (
        .bus_clk(bus_clk), .trn_reset_n(trn_reset_n),
        .user_w_mmreq_data(wdata_bus), .user_w_mmreq_wren(wren), .user_w_mmreq_open(wopen),
        .user_w_mmreq_full(req_full), .user_r_mmresp_data(rsp_data), .user_r_mmresp_rden(rden),
        .user_r_mmresp_open(ropen), .user_r_mmresp_empty(rsp_empty), .user_r_mmresp_eof(rsp_eof),
        .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_ch_o(reg_ch_o), .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i), .timeout_o(timeout_o)
    );

    initial forever #5 bus_clk = ~bus_clk;

    function automatic logic [31:0] fn(input logic [23:0] a);
        return {a[7:0], a} ^ 32'h5A5A_C3C3;
    endfunction

    // register-bus slave: acks after ack_delay cycles of req (0 = never), logs each transaction
    initial begin
        tr_t t;
        reg_ack_i = 1'b0;
        reg_rdata_i = '0;
        forever begin
            @(negedge bus_clk);
            reg_ack_i = 1'b0;
            if (reg_req_o) begin
                wcnt++;
                if (wcnt == 1) begin
                    t.we = reg_we_o;
                    t.addr = reg_addr_o;
                    t.wdata = reg_wdata_o;
                    t.ch = reg_ch_o;
                    log_q.push_back(t);
                end
                if (wcnt == ack_delay) begin
                    reg_ack_i = 1'b1;
                    reg_rdata_i = use_fn ? fn(reg_addr_o) : rd_val;
                end
            end else begin
                if (wcnt > 0) last_hi = wcnt;
                wcnt = 0;
            end
            if (late_req != late_done) begin
                reg_ack_i = 1'b1;
                reg_rdata_i = 32'h0BAD_0BAD;
                late_done = late_req;
            end
            if (timeout_o) to_cnt++;
        end
    end

    task automatic tick;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int c, input logic [31:0] w);
        wdata_bus[32*c +: 32] = w;
        wren[c] = 1'b1;
        tick;
        wren[c] = 1'b0;
    endtask

    task automatic service(input int n);
        logic [NCH-1:0] took;
        for (int k = 0; k < n; k++) begin
            took = ~rsp_empty;
            rden = took;
            tick;
            rden = '0;
            for (int c = 0; c < NCH; c++)
                if (took[c]) got_q[c].push_back(rsp_data[32*c +: 32]);
        end
    endtask

    task automatic expect_rsp(input string tag, input int c, input logic [31:0] e);
        logic [31:0] g;
        g = 'x;
        if (got_q[c].size() > 0) g = got_q[c].pop_front();
        chk(tag, g, e);
    endtask

    task automatic wait_req(input int n);
        int k;
        k = 0;
        while (!reg_req_o && k < n) begin
            tick;
            k++;
        end
        chk("wait_req", reg_req_o, 1);
    endtask

    task automatic do_reset;
        trn_reset_n = 1'b0;
        tick;
        trn_reset_n = 1'b1;
        tick;
    endtask

    initial begin
        logic [31:0] h, d;
        int n, k;
        tr_t t, g;
        wopen = '1;
        ropen = '1;
        wren = '0;
        rden = '0;
        wdata_bus = '0;
        rd_val = '0;
        trn_reset_n = 1'b0;
        tick;
        tick;
        chk("rst_full", req_full, 0);
        chk("rst_empty", rsp_empty, 4'hF);
        chk("rst_data", rsp_data, 0);
        chk("rst_bus", {reg_req_o, reg_we_o, timeout_o, reg_addr_o, reg_ch_o}, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_eof", rsp_eof, 0);
        trn_reset_n = 1'b1;
        tick;

        // single read on ch0, ack two cycles into WAIT
        use_fn = 1'b0;
        rd_val = 32'hCAFE_F00D;
        ack_delay = 2;
        put(0, 32'h0000_0010);
        chk("t1_req_c1", reg_req_o, 0);
        tick;
        chk("t1_req_c2", reg_req_o, 0);
        tick;
        chk("t1_req_c3", reg_req_o, 1);
        chk("t1_hdr", {reg_we_o, reg_addr_o, reg_ch_o}, {1'b0, 24'h10, 2'd0});
        tick;
        chk("t1_empty_wait", rsp_empty[0], 1);
        tick;
        chk("t1_empty_ack", rsp_empty[0], 0);
        chk("t1_req_drop", reg_req_o, 0);
        rden[0] = 1'b1;
        tick;
        rden[0] = 1'b0;
        chk("t1_rdata", rsp_data[31:0], 32'hCAFE_F00D);
        chk("t1_empty_after", rsp_empty[0], 1);
        use_fn = 1'b1;

        // write on ch2: header alone must not issue
        ack_delay = 1;
        log_q.delete();
        put(2, 32'h8000_0044);
        repeat (4) tick;
        chk("t2_hdr_only", reg_req_o, 0);
        put(2, 32'h1234_5678);
        tick;
        tick;
        chk("t2_req", reg_req_o, 1);
        chk("t2_tr", {reg_we_o, reg_addr_o, reg_wdata_o, reg_ch_o}, {1'b1, 24'h44, 32'h1234_5678, 2'd2});
        repeat (4) tick;
        chk("t2_no_rsp", rsp_empty[2], 1);
        chk("t2_count", log_q.size(), 1);

        // round robin from pointer 0 with a re-queued ch0 read
        do_reset;
        log_q.delete();
        for (int c = 0; c < NCH; c++) wdata_bus[32*c +: 32] = 32'h100 + c;
        wren = '1;
        tick;
        wren = '0;
        put(0, 32'h104);
        k = 0;
        while (log_q.size() < 5 && k < 100) begin
            tick;
            k++;
        end
        chk("t3_log_size", log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) chk("t3_order", {log_q[i].ch, log_q[i].addr}, {2'(i % 4), 24'(32'h100 + i)});
        for (int c = 0; c < NCH; c++) got_q[c].delete();
        service(10);
        expect_rsp("t3_rsp0a", 0, fn(24'h100));
        expect_rsp("t3_rsp0b", 0, fn(24'h104));
        expect_rsp("t3_rsp3", 3, fn(24'h103));

        // timeout on a read, then a late ack that must be ignored
        ack_delay = 0;
        to_cnt = 0;
        for (int c = 0; c < NCH; c++) got_q[c].delete();
        put(1, 32'h20);
        wait_req(10);
        n = 0;
        while (reg_req_o && n < 40) begin
            tick;
            n++;
        end
        chk("t4_req_fell", reg_req_o, 0);
        tick;
        chk("t4_hi_cycles", last_hi, 8);
        chk("t4_pulses", to_cnt, 1);
        late_req++;
        repeat (3) tick;
        service(4);
        expect_rsp("t4_err", 1, ERR);
        chk("t4_no_extra", got_q[1].size(), 0);
        chk("t4_pulses_after", to_cnt, 1);

        // response backpressure with RSP_DEPTH=2, then request FIFO overflow
        ack_delay = 1;
        log_q.delete();
        put(1, 32'h30);
        put(1, 32'h31);
        put(1, 32'h32);
        repeat (20) tick;
        chk("t5_two_issued", log_q.size(), 2);
        rden[1] = 1'b1;
        tick;
        rden[1] = 1'b0;
        chk("t5_rd", rsp_data[63:32], fn(24'h30));
        chk("t5_still_two", log_q.size(), 2);
        tick;
        tick;
        chk("t5_third", {reg_req_o, reg_addr_o}, {1'b1, 24'h32});
        repeat (4) tick;
        for (int i = 0; i < 16; i++) put(1, 32'h40 + i);
        chk("t5_full", req_full[1], 1);
        put(1, 32'h50);
        chk("t5_full_hold", req_full[1], 1);
        log_q.delete();
        got_q[1].delete();
        service(300);
        chk("t5_issued", log_q.size(), 16);
        chk("t5_got", got_q[1].size(), 18);
        for (int i = 0; i < 18; i++)
            expect_rsp("t5_rsp", 1, i < 2 ? fn(24'(32'h31 + i)) : fn(24'(32'h40 + i - 2)));

        // response stream closed while the read is in flight
        ack_delay = 5;
        put(1, 32'h60);
        wait_req(10);
        tick;
        ropen[1] = 1'b0;
        n = 0;
        while (reg_req_o && n < 20) begin
            tick;
            n++;
        end
        chk("t6_req_done", reg_req_o, 0);
        tick;
        ropen[1] = 1'b1;
        tick;
        chk("t6_discard", rsp_empty[1], 1);
        ack_delay = 1;
        got_q[1].delete();
        put(1, 32'h61);
        service(20);
        expect_rsp("t6_reopen", 1, fn(24'h61));
        chk("t6_count", got_q[1].size(), 0);

        // randomized traffic against per-channel ordering model
        for (int r = 0; r < 15; r++) begin
            log_q.delete();
            for (int c = 0; c < NCH; c++) begin
                got_q[c].delete();
                exp_tr[c].delete();
                exp_rsp[c].delete();
            end
            ack_delay = $urandom_range(1, 4);
            for (int c = 0; c < NCH; c++) begin
                n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) begin
                    h = $urandom;
                    t.we = h[31];
                    t.addr = h[23:0];
                    t.ch = 2'(c);
                    t.wdata = '0;
                    put(c, h);
                    if (h[31]) begin
                        d = $urandom;
                        t.wdata = d;
                        put(c, d);
                    end else exp_rsp[c].push_back(fn(h[23:0]));
                    exp_tr[c].push_back(t);
                end
            end
            service(200);
            for (int i = 0; i < log_q.size(); i++) begin
                g = log_q[i];
                t = 'x;
                if (exp_tr[g.ch].size() > 0) t = exp_tr[g.ch].pop_front();
                chk("rnd_tr", {g.we, g.addr, g.we ? g.wdata : 32'h0}, {t.we, t.addr, t.wdata});
            end
            for (int c = 0; c < NCH; c++) begin
                chk("rnd_pending", exp_tr[c].size(), 0);
                while (exp_rsp[c].size() > 0) expect_rsp("rnd_rsp", c, exp_rsp[c].pop_front());
                chk("rnd_extra", got_q[c].size(), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
